antifurto_multizona: RTL and testbench
======================================

ANTIFURTO_MULTIZONA -- requirements
Module: antifurto_multizona

Interface
REQ-001 Parameter NUM_DOORS, default 2, number of door inputs (1..8); bit 0 is the driver door.
REQ-002 Parameter TIMER_W, default 4, width of time parameters and countdown.
REQ-003 Parameters T_ARM_DEF 6, T_DRIVER_DEF 8, T_PASS_DEF 15, T_ALARM_DEF 10: reset values of the four time parameters, in seconds.
REQ-004 clock  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 one_hz_enable  in  1  single-cycle tick, once per second.
REQ-007 ignition  in  1  ignition on.
REQ-008 doors  in  NUM_DOORS  per-door open flag (1 = open).
REQ-009 reprogram  in  1  write strobe for a time parameter.
REQ-010 time_param_sel  in  2  parameter select: 00 T_ARM, 01 T_DRIVER, 10 T_PASS, 11 T_ALARM.
REQ-011 time_value  in  TIMER_W  value written on reprogram.
REQ-012 status  out  2  00 ARMED, 01 TRIGGERED, 10 ALARM, 11 any disarmed sub-state.
REQ-013 interval  out  2  code of the parameter last loaded into the countdown.
REQ-014 siren_en  out  1  high only in ALARM.
REQ-015 timer_value  out  TIMER_W  current countdown value.
REQ-016 trig_zone  out  3  index of the door that caused the last trigger.

Function
REQ-017 States: ARMED, TRIGGERED, ALARM, D_IGN, D_WAIT_OPEN, D_WAIT_CLOSE, ARMING.
REQ-018 All outputs are registered or decoded from registered state only; no input-to-output combinational path.
REQ-019 Countdown: loaded with the selected parameter on the transition into a timed state (TRIGGERED, ALARM, ARMING); decrements by 1 on each one_hz_enable while nonzero; holds at 0.
REQ-020 Expired = (countdown == 0) while in a timed state; the resulting transition occurs on the next clock edge, so a loaded value N lasts N ticks plus one cycle, and a loaded value 0 expires one cycle after entry.
REQ-021 ARMED: ignition -> D_IGN; else any door open -> TRIGGERED, loading T_DRIVER if doors[0] is open, else T_PASS; trig_zone latches the lowest-index open door.
REQ-022 TRIGGERED: ignition -> D_IGN; else expired -> ALARM, loading T_ALARM.
REQ-023 ALARM: ignition -> D_IGN; else on expiry, any door open -> remain in ALARM with T_ALARM reloaded; all doors closed -> ARMED.
REQ-024 D_IGN: ignition low -> D_WAIT_OPEN.
REQ-025 D_WAIT_OPEN: ignition -> D_IGN; else doors[0] open -> D_WAIT_CLOSE.
REQ-026 D_WAIT_CLOSE: ignition -> D_IGN; else all doors closed -> ARMING, loading T_ARM.
REQ-027 ARMING: ignition -> D_IGN; else any door open -> D_WAIT_CLOSE; else expired -> ARMED.
REQ-028 Reprogram: param[time_param_sel] <= time_value; same edge forces ARMED, countdown 0, siren_en 0; the new value applies to the next load.
REQ-029 Priority when events coincide: reset > reprogram > ignition > door/expiry.
REQ-030 In ARMED and the disarmed sub-states, countdown holds its value and is not decremented.
REQ-031 trig_zone changes only on entry to TRIGGERED.

Reset
REQ-032 On reset: state ARMED, countdown 0, interval 00, trig_zone 0, siren_en 0, and all parameters restored to their _DEF values.
REQ-033 Reset applied mid-ALARM or mid-ARMING takes effect at the next edge, overriding all other inputs.

Verification
REQ-034 Reset, ARMED, doors=01 -> TRIGGERED, interval 01, timer 8; after 8 ticks plus 1 cycle -> ALARM, siren_en 1, timer 10, trig_zone 0.
REQ-035 ARMED, doors=10 -> TRIGGERED, interval 10, timer 15, trig_zone 1; ignition during TRIGGERED -> status 11, siren_en 0.
REQ-036 ALARM expiring with doors=10 -> stays ALARM, timer reloads 10; close doors and wait for the next expiry -> ARMED.
REQ-037 Ignition on then off, open and close driver door -> ARMING, timer 6; open a door at tick 3 -> D_WAIT_CLOSE; close -> ARMING, timer 6; after 6 ticks -> ARMED.
REQ-038 Reprogram sel=11, value 3 during ALARM -> ARMED, siren_en 0; next trigger-to-alarm cycle loads timer 3.
REQ-039 Reprogram sel=00, value 0 -> ARMING expires one cycle after entry; reprogram and reset asserted on the same edge -> reset wins, T_ARM = 6.

Source files
------------

// File: rtl/antifurto_multizona.sv
// -----------------------------------------------------------------------------
// antifurto_multizona
//
// Multi-zone vehicle anti-theft controller. While armed, opening any door
// starts an entry delay: the driver-door delay if the driver door is open,
// otherwise the passenger-door delay. If the ignition is not switched on
// before the delay runs out, the siren sounds for a programmable time. The
// siren keeps retriggering while any door is still open. Switching the
// ignition on disarms. Arming again requires the ignition off, the driver
// door opened and closed, and then an exit delay with all doors closed.
//
// Ports
//   clock          : system clock, rising-edge
//   reset          : synchronous, active-high
//   one_hz_enable  : single-cycle tick once per second
//   ignition       : ignition on
//   doors          : per-door open flags (bit 0 = driver door)
//   reprogram      : write strobe for a time parameter
//   time_param_sel : 00 T_ARM, 01 T_DRIVER, 10 T_PASS, 11 T_ALARM
//   time_value     : value written on reprogram
//   status         : 00 ARMED, 01 TRIGGERED, 10 ALARM, 11 disarmed sub-state
//   interval       : code of the parameter last loaded into the countdown
//   siren_en       : high only in ALARM
//   timer_value    : current countdown value
//   trig_zone      : index of the door that caused the last trigger
// -----------------------------------------------------------------------------
module antifurto_multizona #(
   parameter int unsigned NUM_DOORS    = 2,
   parameter int unsigned TIMER_W      = 4,
   parameter int unsigned T_ARM_DEF    = 6,
   parameter int unsigned T_DRIVER_DEF = 8,
   parameter int unsigned T_PASS_DEF   = 15,
   parameter int unsigned T_ALARM_DEF  = 10
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 one_hz_enable,
   input  logic                 ignition,
   input  logic [NUM_DOORS-1:0] doors,
   input  logic                 reprogram,
   input  logic [1:0]           time_param_sel,
   input  logic [TIMER_W-1:0]   time_value,
   output logic [1:0]           status,
   output logic [1:0]           interval,
   output logic                 siren_en,
   output logic [TIMER_W-1:0]   timer_value,
   output logic [2:0]           trig_zone
);

   typedef enum logic [2:0] {
      S_ARMED,
      S_TRIGGERED,
      S_ALARM,
      S_D_IGN,
      S_D_WAIT_OPEN,
      S_D_WAIT_CLOSE,
      S_ARMING
   } state_t;

   // Parameter-table indices, also the values reported on interval.
   localparam logic [1:0] SEL_ARM    = 2'b00;
   localparam logic [1:0] SEL_DRIVER = 2'b01;
   localparam logic [1:0] SEL_PASS   = 2'b10;
   localparam logic [1:0] SEL_ALARM  = 2'b11;

   state_t             r_state;
   logic [TIMER_W-1:0] r_count;
   logic [1:0]         r_interval;
   logic [2:0]         r_trig_zone;
   logic [TIMER_W-1:0] r_param [4];

   state_t             w_next_state;
   logic               w_load;
   logic [1:0]         w_load_sel;
   logic               w_timed;
   logic               w_expired;
   logic               w_any_open;
   logic               w_latch_zone;
   logic [2:0]         w_first_door;

   assign w_any_open = |doors;
   assign w_timed    = (r_state == S_TRIGGERED) || (r_state == S_ALARM) ||
                       (r_state == S_ARMING);
   assign w_expired  = w_timed && (r_count == '0);

   // Lowest-index open door; scanning downward lets the lowest index win.
   always_comb begin
      w_first_door = '0;
      for (int unsigned i = NUM_DOORS; i > 0; i--) begin
         if (doors[i-1]) begin
            w_first_door = 3'(i - 1);
         end
      end
   end

   // Next-state logic and countdown load request.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_load_sel   = SEL_ARM;
      w_latch_zone = 1'b0;

      case (r_state)
         S_ARMED: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (w_any_open) begin
               w_next_state = S_TRIGGERED;
               w_load       = 1'b1;
               w_load_sel   = doors[0] ? SEL_DRIVER : SEL_PASS;
               w_latch_zone = 1'b1;
            end
         end

         S_TRIGGERED: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (w_expired) begin
               w_next_state = S_ALARM;
               w_load       = 1'b1;
               w_load_sel   = SEL_ALARM;
            end
         end

         S_ALARM: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (w_expired) begin
               if (w_any_open) begin
                  // Staying in ALARM still counts as a fresh entry: reload.
                  w_next_state = S_ALARM;
                  w_load       = 1'b1;
                  w_load_sel   = SEL_ALARM;
               end else begin
                  w_next_state = S_ARMED;
               end
            end
         end

         S_D_IGN: begin
            if (!ignition) begin
               w_next_state = S_D_WAIT_OPEN;
            end
         end

         S_D_WAIT_OPEN: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (doors[0]) begin
               w_next_state = S_D_WAIT_CLOSE;
            end
         end

         S_D_WAIT_CLOSE: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (!w_any_open) begin
               w_next_state = S_ARMING;
               w_load       = 1'b1;
               w_load_sel   = SEL_ARM;
            end
         end

         S_ARMING: begin
            if (ignition) begin
               w_next_state = S_D_IGN;
            end else if (w_any_open) begin
               w_next_state = S_D_WAIT_CLOSE;
            end else if (w_expired) begin
               w_next_state = S_ARMED;
            end
         end

         default: begin
            w_next_state = S_ARMED;
         end
      endcase
   end

   // State, countdown and parameter registers. Reprogram overrides the
   // normal transition and parks the controller in ARMED with the
   // countdown cleared; the new value is only seen at the next load.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_ARMED;
         r_count     <= '0;
         r_interval  <= SEL_ARM;
         r_trig_zone <= '0;
         r_param[0]  <= TIMER_W'(T_ARM_DEF);
         r_param[1]  <= TIMER_W'(T_DRIVER_DEF);
         r_param[2]  <= TIMER_W'(T_PASS_DEF);
         r_param[3]  <= TIMER_W'(T_ALARM_DEF);
      end else if (reprogram) begin
         r_param[time_param_sel] <= time_value;
         r_state                 <= S_ARMED;
         r_count                 <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_load) begin
            r_count    <= r_param[w_load_sel];
            r_interval <= w_load_sel;
         end else if (w_timed && one_hz_enable && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
         end
         if (w_latch_zone) begin
            r_trig_zone <= w_first_door;
         end
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      case (r_state)
         S_ARMED:     status = 2'b00;
         S_TRIGGERED: status = 2'b01;
         S_ALARM:     status = 2'b10;
         default:     status = 2'b11;
      endcase
   end

   assign siren_en    = (r_state == S_ALARM);
   assign interval    = r_interval;
   assign timer_value = r_count;
   assign trig_zone   = r_trig_zone;

endmodule

// File: tb/tb_antifurto_multizona.sv
// -----------------------------------------------------------------------------
// tb_antifurto_multizona
//
// Directed scenarios followed by randomized stimulus; every cycle the DUT
// outputs are compared against a behavioural model of the alarm rules.
// -----------------------------------------------------------------------------
module tb_antifurto_multizona;

   localparam int NDOORS = 2;
   localparam int TW     = 4;

   // Model modes (plain integers, named after the behaviour they describe).
   localparam int M_ARMED   = 0;
   localparam int M_TRIG    = 1;
   localparam int M_ALARM   = 2;
   localparam int M_IGN     = 3;
   localparam int M_W_OPEN  = 4;
   localparam int M_W_CLOSE = 5;
   localparam int M_ARMING  = 6;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              one_hz_enable = 1'b0;
   logic              ignition = 1'b0;
   logic [NDOORS-1:0] doors = '0;
   logic              reprogram = 1'b0;
   logic [1:0]        time_param_sel = 2'b00;
   logic [TW-1:0]     time_value = '0;
   logic [1:0]        status;
   logic [1:0]        interval;
   logic              siren_en;
   logic [TW-1:0]     timer_value;
   logic [2:0]        trig_zone;

   int checks   = 0;
   int failures = 0;

   int m_mode = M_ARMED;
   int m_cnt  = 0;
   int m_int  = 0;
   int m_zone = 0;
   int m_par [4] = '{6, 8, 15, 10};

   antifurto_multizona #(
      .NUM_DOORS   (NDOORS),
      .TIMER_W     (TW),
      .T_ARM_DEF   (6),
      .T_DRIVER_DEF(8),
      .T_PASS_DEF  (15),
      .T_ALARM_DEF (10)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .one_hz_enable (one_hz_enable),
      .ignition      (ignition),
      .doors         (doors),
      .reprogram     (reprogram),
      .time_param_sel(time_param_sel),
      .time_value    (time_value),
      .status        (status),
      .interval      (interval),
      .siren_en      (siren_en),
      .timer_value   (timer_value),
      .trig_zone     (trig_zone)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock of the alarm rules, applied to the inputs currently driven.
   task automatic model_step();
      bit timed;
      bit expired;
      bit any_open;
      int nxt;
      int ld;
      timed    = (m_mode == M_TRIG) || (m_mode == M_ALARM) || (m_mode == M_ARMING);
      expired  = timed && (m_cnt == 0);
      any_open = (doors != 0);
      nxt      = m_mode;
      ld       = -1;
      if (reset) begin
         m_mode = M_ARMED;
         m_cnt  = 0;
         m_int  = 0;
         m_zone = 0;
         m_par  = '{6, 8, 15, 10};
      end else if (reprogram) begin
         m_par[time_param_sel] = int'(time_value);
         m_mode = M_ARMED;
         m_cnt  = 0;
      end else begin
         if (ignition) begin
            // Ignition disarms from anywhere (D_IGN just stays).
            nxt = M_IGN;
         end else begin
            case (m_mode)
               M_ARMED:   if (any_open) begin nxt = M_TRIG; ld = doors[0] ? 1 : 2; end
               M_TRIG:    if (expired) begin nxt = M_ALARM; ld = 3; end
               M_ALARM:   if (expired) begin
                             if (any_open) ld = 3;
                             else nxt = M_ARMED;
                          end
               M_IGN:     nxt = M_W_OPEN;
               M_W_OPEN:  if (doors[0]) nxt = M_W_CLOSE;
               M_W_CLOSE: if (!any_open) begin nxt = M_ARMING; ld = 0; end
               M_ARMING:  if (any_open) nxt = M_W_CLOSE;
                          else if (expired) nxt = M_ARMED;
               default:   nxt = m_mode;
            endcase
         end
         if (ld >= 0) begin
            m_cnt = m_par[ld];
            m_int = ld;
         end else if (timed && one_hz_enable && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
         end
         if (m_mode == M_ARMED && nxt == M_TRIG) begin
            for (int i = NDOORS - 1; i >= 0; i--) if (doors[i]) m_zone = i;
         end
         m_mode = nxt;
      end
   endtask

   function automatic int exp_status(input int mode);
      if (mode == M_ARMED) return 0;
      if (mode == M_TRIG)  return 1;
      if (mode == M_ALARM) return 2;
      return 3;
   endfunction

   // Advance one clock and compare every output with the model.
   task automatic cycle();
      model_step();
      @(posedge clock);
      #1;
      chk("status",    32'(status),      32'(exp_status(m_mode)));
      chk("siren_en",  32'(siren_en),    32'(m_mode == M_ALARM));
      chk("interval",  32'(interval),    32'(m_int));
      chk("timer",     32'(timer_value), 32'(m_cnt));
      chk("trig_zone", 32'(trig_zone),   32'(m_zone));
   endtask

   // n one-second ticks, each followed by a quiet cycle.
   task automatic run_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         one_hz_enable = 1'b1;
         cycle();
         one_hz_enable = 1'b0;
         cycle();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   task automatic arm_sequence();
      ignition = 1'b1;  cycle();
      ignition = 1'b0;  cycle();
      doors = 2'b01;    cycle();
      doors = 2'b00;    cycle();
   endtask

   initial begin
      // Reset state
      cycle();
      reset = 1'b0;
      chk("rst_status", 32'(status), 0);
      chk("rst_timer", 32'(timer_value), 0);
      chk("rst_interval", 32'(interval), 0);
      chk("rst_zone", 32'(trig_zone), 0);
      chk("rst_siren", 32'(siren_en), 0);

      // Driver door trigger, then alarm after 8 ticks plus a cycle
      doors = 2'b01; cycle();
      chk("drv_status", 32'(status), 1);
      chk("drv_interval", 32'(interval), 1);
      chk("drv_timer", 32'(timer_value), 8);
      run_ticks(8);
      chk("drv_alarm", 32'(status), 2);
      chk("drv_siren", 32'(siren_en), 1);
      chk("drv_alarm_timer", 32'(timer_value), 10);
      chk("drv_zone", 32'(trig_zone), 0);

      // Passenger door trigger, ignition disarms
      doors = 2'b00; do_reset();
      doors = 2'b10; cycle();
      chk("pas_status", 32'(status), 1);
      chk("pas_interval", 32'(interval), 2);
      chk("pas_timer", 32'(timer_value), 15);
      chk("pas_zone", 32'(trig_zone), 1);
      ignition = 1'b1; cycle();
      chk("ign_status", 32'(status), 3);
      chk("ign_siren", 32'(siren_en), 0);
      ignition = 1'b0;

      // Alarm retriggers while a door is open, re-arms once closed
      doors = 2'b00; do_reset();
      doors = 2'b10; cycle();
      run_ticks(15);
      chk("alm_enter", 32'(status), 2);
      run_ticks(10);
      chk("alm_stay", 32'(status), 2);
      chk("alm_reload", 32'(timer_value), 10);
      doors = 2'b00;
      run_ticks(10);
      chk("alm_rearm", 32'(status), 0);
      chk("alm_rearm_siren", 32'(siren_en), 0);

      // Arming sequence, interrupted by a door at tick 3
      arm_sequence();
      chk("arm_status", 32'(status), 3);
      chk("arm_interval", 32'(interval), 0);
      chk("arm_timer", 32'(timer_value), 6);
      run_ticks(3);
      chk("arm_tick3", 32'(timer_value), 3);
      doors = 2'b10; cycle();
      doors = 2'b00; cycle();
      chk("arm_restart", 32'(timer_value), 6);
      run_ticks(6);
      chk("arm_done", 32'(status), 0);

      // Reprogram T_ALARM during ALARM
      doors = 2'b01; cycle();
      run_ticks(8);
      chk("rp_in_alarm", 32'(status), 2);
      reprogram = 1'b1; time_param_sel = 2'b11; time_value = 4'd3; cycle();
      reprogram = 1'b0;
      chk("rp_status", 32'(status), 0);
      chk("rp_siren", 32'(siren_en), 0);
      chk("rp_timer", 32'(timer_value), 0);
      cycle();
      run_ticks(8);
      chk("rp_alarm_timer", 32'(timer_value), 3);

      // Reset mid-ALARM overrides ignition and doors
      ignition = 1'b1; reset = 1'b1; cycle();
      reset = 1'b0; ignition = 1'b0; doors = 2'b00;
      chk("rst_mid_alarm", 32'(status), 0);

      // T_ARM = 0 expires one cycle after entry
      reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd0; cycle();
      reprogram = 1'b0;
      arm_sequence();
      chk("arm0_entry", 32'(status), 3);
      chk("arm0_timer", 32'(timer_value), 0);
      cycle();
      chk("arm0_expired", 32'(status), 0);

      // Reset beats reprogram on the same edge
      reset = 1'b1; reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd9; cycle();
      reset = 1'b0; reprogram = 1'b0;
      arm_sequence();
      chk("rst_over_rp", 32'(timer_value), 6);

      // Randomized phase
      for (int n = 0; n < 4000; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         reprogram      = ($urandom_range(0, 79) == 0);
         time_param_sel = 2'($urandom_range(0, 3));
         time_value     = 4'($urandom_range(0, 7));
         one_hz_enable  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 24) == 0) ignition = ~ignition;
         if ($urandom_range(0, 5) == 0) doors = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
